// File: rtl/ro_count_averager_pkg.sv
// Shared types for the ring-oscillator temperature-sense readout path.
// State encoding for the window averager FSM.
package ro_tempsens_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/ro_count_averager_if.sv
// Valid/ready result channel from the window averager to the readout logic.
interface ro_count_averager_if #(
    parameter int N = 8
);

    logic [N-1:0] result;
    logic         result_valid;
    logic         result_ready;

    modport master (
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/ro_window_detect.sv
// Watches the upstream window counter and flags the cycle where a window ends,
// separating clean window ends from saturated (overflowed) ones.
module ro_window_detect #(
    parameter int N = 8
) (
    input  logic         osc_clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] count,
    output logic         evt,
    output logic         ovf,
    output logic [N-1:0] sample
);

    localparam logic [N-1:0] MAXCOUNT = '1;

    logic [N-1:0] r_prev;
    logic         r_enQ;
    logic         w_wrap;

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_prev <= '0;
            r_enQ  <= 1'b0;
        end else begin
            r_prev <= count;
            r_enQ  <= en;
        end
    end

    // A window ends when the counter drops back to zero from a nonzero value
    // while the enable has been steady for at least one cycle.
    assign w_wrap = en && r_enQ && (r_prev != '0) && (count == '0);
    assign evt    = w_wrap && (r_prev != MAXCOUNT);
    assign ovf    = w_wrap && (r_prev == MAXCOUNT);
    assign sample = r_prev;

endmodule

// File: rtl/ro_count_averager.sv
// Averages 2^AVG_LOG2 complete reference windows of the ring-oscillator counter
// and presents each average on a registered valid/ready channel.
module ro_count_averager
    import ro_tempsens_pkg::*;
#(
    parameter int N        = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                osc_clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N-1:0]        count,
    output logic                overflow,
    ro_count_averager_if.master rd
);

    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int AW    = N + AVG_LOG2;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LASTSAMP = CW'(NSAMP - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_nSamp;
    logic [N-1:0]  r_result;
    logic          r_valid;
    logic          r_overflow;
    logic          r_rearm;

    logic          w_evt;
    logic          w_ovf;
    logic [N-1:0]  w_sample;
    logic [AW-1:0] w_sum;
    logic          w_lastSample;
    logic          w_handshake;

    logic          w_accClear;
    logic          w_accAdd;
    logic          w_loadResult;
    logic          w_clearValid;
    logic          w_setOverflow;
    logic          w_setRearm;

    ro_window_detect #(.N(N)) u_detect (
        .osc_clk (osc_clk),
        .reset   (reset),
        .en      (en),
        .count   (count),
        .evt     (w_evt),
        .ovf     (w_ovf),
        .sample  (w_sample)
    );

    assign w_sum        = r_acc + AW'(w_sample);
    assign w_lastSample = (r_nSamp == LASTSAMP);
    assign w_handshake  = r_valid && rd.result_ready;

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An overflow seen on the accept cycle means the window now running is
    // partial, so it forces a rearm just like a registered rearm would.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (en) w_nextState = ARM;
            ARM: begin
                if (!en)        w_nextState = IDLE;
                else if (w_ovf) w_nextState = ARM;
                else if (w_evt) w_nextState = ACC;
            end
            ACC: begin
                if (!en)                        w_nextState = IDLE;
                else if (w_ovf)                 w_nextState = ARM;
                else if (w_evt && w_lastSample) w_nextState = HOLD;
            end
            HOLD: begin
                if (w_handshake) begin
                    if (!en)                    w_nextState = IDLE;
                    else if (r_rearm || w_ovf)  w_nextState = ARM;
                    else                        w_nextState = ACC;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_accClear    = 1'b0;
        w_accAdd      = 1'b0;
        w_loadResult  = 1'b0;
        w_clearValid  = 1'b0;
        w_setOverflow = 1'b0;
        w_setRearm    = 1'b0;
        unique case (r_state)
            IDLE: ;
            ARM: begin
                w_accClear    = !en || w_ovf;
                w_setOverflow = w_ovf;
            end
            ACC: begin
                if (!en || w_ovf) begin
                    w_accClear    = 1'b1;
                    w_setOverflow = w_ovf;
                end else if (w_evt) begin
                    w_accAdd     = !w_lastSample;
                    w_loadResult = w_lastSample;
                    w_accClear   = w_lastSample;
                end
            end
            HOLD: begin
                w_setOverflow = w_ovf;
                w_setRearm    = !en || w_ovf;
                w_clearValid  = w_handshake;
            end
            default: ;
        endcase
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_nSamp    <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_rearm    <= 1'b0;
        end else begin
            if (w_accClear) begin
                r_acc   <= '0;
                r_nSamp <= '0;
            end else if (w_accAdd) begin
                r_acc   <= w_sum;
                r_nSamp <= r_nSamp + CW'(1);
            end
            if (w_loadResult) begin
                r_result <= w_sum[AVG_LOG2 +: N];
                r_valid  <= 1'b1;
            end else if (w_clearValid) begin
                r_valid  <= 1'b0;
            end
            if (w_setOverflow) r_overflow <= 1'b1;
            if (r_state == HOLD && w_nextState != HOLD) r_rearm <= 1'b0;
            else if (w_setRearm)                        r_rearm <= 1'b1;
        end
    end

    assign rd.result       = r_result;
    assign rd.result_valid = r_valid;
    assign overflow        = r_overflow;

endmodule
